// File: rtl/lcd_bus_decoder.sv
// lcd_bus_decoder
//   Passive receiver for an HD44780-style 4-bit LCD bus. It follows the
//   controller init sequence and reassembles nibble pairs into bytes. It also
//   keeps a shadow DDRAM cursor. Each written character is reported as a
//   (row, column, char) pulse. Every other command byte is reported on the
//   command output.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   db[3:0]             LCD data nibble
//   lcd_e               enable strobe (a byte nibble is taken on its falling edge)
//   lcd_rs              0 = command, 1 = data
//   lcd_rw_n            0 = write, 1 = read (read strobes are ignored)
//   char_valid          one-cycle pulse: character written
//   char_row            row of the character (DDRAM address bit 6)
//   char_column[6:0]    column of the character, {1'b0, addr[5:0]}
//   char_code[7:0]      character byte
//   cmd_valid           one-cycle pulse: command byte received in 4-bit mode
//   cmd_code[7:0]       command byte
//   mode_4bit           set once the switch to 4-bit mode has been seen
//   err[2:0]            sticky: [0] rs mismatch between nibbles,
//                       [1] illegal DDRAM address set, [2] short E pulse
module lcd_bus_decoder #(
  parameter bit          START_4BIT = 1'b0,
  parameter int unsigned MIN_E_HIGH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] db,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw_n,
  output logic       char_valid,
  output logic       char_row,
  output logic [6:0] char_column,
  output logic [7:0] char_code,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       mode_4bit,
  output logic [2:0] err
);

  typedef enum logic [1:0] {S_INIT, S_HI, S_LO} state_t;
  localparam state_t RESET_STATE = START_4BIT ? S_HI : S_INIT;
  localparam logic [3:0] MIN_HIGH = 4'(MIN_E_HIGH);

  // Input register stage
  logic       e_q, e_d;
  logic [3:0] db_q, db_d;
  logic       rs_q, rs_d;
  logic       rw_n_q, rw_n_d;

  // E-high counter and the bus values seen in the last E-high cycle
  logic [3:0] hcnt_q, hcnt_d;
  logic [3:0] db_lat_q, db_lat_d;
  logic       rs_lat_q, rs_lat_d;
  logic       rw_lat_q, rw_lat_d;

  // Decoder state
  state_t     state_q, state_d;
  logic [3:0] hi_q, hi_d;
  logic       hi_rs_q, hi_rs_d;
  logic [6:0] addr_q, addr_d;
  logic       inc_q, inc_d;

  // Registered outputs
  logic       char_valid_q, char_valid_d;
  logic       char_row_q, char_row_d;
  logic [6:0] char_column_q, char_column_d;
  logic [7:0] char_code_q, char_code_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [7:0] cmd_code_q, cmd_code_d;
  logic       mode_4bit_q, mode_4bit_d;
  logic [2:0] err_q, err_d;

  logic       strobe;
  logic [7:0] byte_w;

  function automatic logic addr_legal(input logic [6:0] a);
    return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
  endfunction

  // Cursor step with the two-line wrap. An illegal address never equals one
  // of the wrap points, so it falls through to a plain 7-bit +/-1.
  function automatic logic [6:0] cursor_step(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  // A falling registered E shows up as E low while the counter still holds
  // the length of the pulse that just ended.
  assign strobe = !e_q && (hcnt_q != 4'd0);
  assign byte_w = {hi_q, db_lat_q};

  always_comb begin
    e_d           = lcd_e;
    db_d          = db;
    rs_d          = lcd_rs;
    rw_n_d        = lcd_rw_n;
    hcnt_d        = 4'd0;
    db_lat_d      = db_lat_q;
    rs_lat_d      = rs_lat_q;
    rw_lat_d      = rw_lat_q;
    state_d       = state_q;
    hi_d          = hi_q;
    hi_rs_d       = hi_rs_q;
    addr_d        = addr_q;
    inc_d         = inc_q;
    char_valid_d  = 1'b0;
    char_row_d    = char_row_q;
    char_column_d = char_column_q;
    char_code_d   = char_code_q;
    cmd_valid_d   = 1'b0;
    cmd_code_d    = cmd_code_q;
    mode_4bit_d   = mode_4bit_q;
    err_d         = err_q;

    if (e_q) begin
      hcnt_d   = (hcnt_q == 4'hF) ? 4'hF : hcnt_q + 4'd1;
      db_lat_d = db_q;
      rs_lat_d = rs_q;
      rw_lat_d = rw_n_q;
    end

    if (strobe && !rw_lat_q) begin
      if (hcnt_q < MIN_HIGH) begin
        err_d[2] = 1'b1;
      end else begin
        case (state_q)
          S_INIT: begin
            // 8-bit mode: only the function-set nibble 0x2 switches to 4-bit
            if (!rs_lat_q && (db_lat_q == 4'h2)) begin
              state_d     = S_HI;
              mode_4bit_d = 1'b1;
            end
          end
          S_HI: begin
            hi_d    = db_lat_q;
            hi_rs_d = rs_lat_q;
            state_d = S_LO;
          end
          S_LO: begin
            state_d = S_HI;
            if (rs_lat_q != hi_rs_q) begin
              err_d[0] = 1'b1;
            end else if (rs_lat_q) begin
              char_valid_d  = 1'b1;
              char_row_d    = addr_q[6];
              char_column_d = {1'b0, addr_q[5:0]};
              char_code_d   = byte_w;
              addr_d        = cursor_step(addr_q, inc_q);
            end else begin
              cmd_valid_d = 1'b1;
              cmd_code_d  = byte_w;
              if (byte_w == 8'h01) begin
                addr_d = 7'h00;
                inc_d  = 1'b1;
              end else if (byte_w[7:1] == 7'h01) begin
                addr_d = 7'h00;
              end else if (byte_w[7:2] == 6'h01) begin
                inc_d = byte_w[1];
              end else if (byte_w[7]) begin
                addr_d = byte_w[6:0];
                if (!addr_legal(byte_w[6:0])) err_d[1] = 1'b1;
              end
            end
          end
          default: state_d = RESET_STATE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q           <= 1'b0;
      db_q          <= 4'd0;
      rs_q          <= 1'b0;
      rw_n_q        <= 1'b0;
      hcnt_q        <= 4'd0;
      db_lat_q      <= 4'd0;
      rs_lat_q      <= 1'b0;
      rw_lat_q      <= 1'b0;
      state_q       <= RESET_STATE;
      hi_q          <= 4'd0;
      hi_rs_q       <= 1'b0;
      addr_q        <= 7'h00;
      inc_q         <= 1'b1;
      char_valid_q  <= 1'b0;
      char_row_q    <= 1'b0;
      char_column_q <= 7'd0;
      char_code_q   <= 8'd0;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= 8'd0;
      mode_4bit_q   <= START_4BIT;
      err_q         <= 3'b000;
    end else begin
      e_q           <= e_d;
      db_q          <= db_d;
      rs_q          <= rs_d;
      rw_n_q        <= rw_n_d;
      hcnt_q        <= hcnt_d;
      db_lat_q      <= db_lat_d;
      rs_lat_q      <= rs_lat_d;
      rw_lat_q      <= rw_lat_d;
      state_q       <= state_d;
      hi_q          <= hi_d;
      hi_rs_q       <= hi_rs_d;
      addr_q        <= addr_d;
      inc_q         <= inc_d;
      char_valid_q  <= char_valid_d;
      char_row_q    <= char_row_d;
      char_column_q <= char_column_d;
      char_code_q   <= char_code_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_code_q    <= cmd_code_d;
      mode_4bit_q   <= mode_4bit_d;
      err_q         <= err_d;
    end
  end

  assign char_valid  = char_valid_q;
  assign char_row    = char_row_q;
  assign char_column = char_column_q;
  assign char_code   = char_code_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign mode_4bit   = mode_4bit_q;
  assign err         = err_q;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Testbench for lcd_bus_decoder (START_4BIT=0, MIN_E_HIGH=2).
// Drives the 4-bit LCD bus and pushes the expected pulse for each byte onto a
// scoreboard queue. The expected entry includes the cycle in which the pulse
// is due. A negedge monitor pops and compares every pulse.
module tb_lcd_bus_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] db = 4'd0;
  logic       lcd_e = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw_n = 1'b0;
  logic       char_valid, char_row, cmd_valid, mode_4bit;
  logic [6:0] char_column;
  logic [7:0] char_code, cmd_code;
  logic [2:0] err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  lcd_bus_decoder #(.START_4BIT(1'b0), .MIN_E_HIGH(2)) dut (
    .clk(clk), .rst_n(rst_n), .db(db), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
    .lcd_rw_n(lcd_rw_n), .char_valid(char_valid), .char_row(char_row),
    .char_column(char_column), .char_code(char_code), .cmd_valid(cmd_valid),
    .cmd_code(cmd_code), .mode_4bit(mode_4bit), .err(err)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_char;
    bit         row;
    logic [6:0] col;
    logic [7:0] code;
    int         due;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    bit         rs;
    logic [7:0] b;
    bit         row;
    logic [6:0] col;
  } vec_t;
  vec_t tbl[$];

  // Scoreboard monitor
  always @(negedge clk) begin
    if (char_valid && cmd_valid) begin
      checks++; failures++;
      $display("FAIL both_valid cyc=%0d char_valid=1 cmd_valid=1 required at most one", cyc);
    end else if (char_valid || cmd_valid) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d char_valid=%0b cmd_valid=%0b required none",
                 cyc, char_valid, cmd_valid);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (e.is_char != char_valid || e.due != cyc ||
            (e.is_char && (char_row != e.row || char_column != e.col || char_code != e.code)) ||
            (!e.is_char && cmd_code != e.code)) begin
          failures++;
          $display("FAIL pulse cyc=%0d got char=%0b row=%0b col=%0d char_code=%02h cmd_code=%02h; required char=%0b row=%0b col=%0d code=%02h at cyc=%0d",
                   cyc, char_valid, char_row, char_column, char_code, cmd_code,
                   e.is_char, e.row, e.col, e.code, e.due);
        end else begin
          $display("pulse ok cyc=%0d char=%0b row=%0b col=%0d code=%02h",
                   cyc, e.is_char, e.row, e.col, e.code);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One E pulse of h cycles; returns the cycle in which E was dropped.
  task automatic e_pulse(input bit rs, input bit rw, input logic [3:0] d, input int h,
                         output int drop);
    @(posedge clk); #1;
    db = d; lcd_rs = rs; lcd_rw_n = rw; lcd_e = 1'b1;
    repeat (h) @(posedge clk);
    #1;
    lcd_e = 1'b0;
    drop = cyc;
  endtask

  // Full byte; when exp_pulse is set the expected pulse is queued.
  task automatic send_byte(input bit rs, input logic [7:0] b, input bit exp_pulse,
                           input bit row, input logic [6:0] col);
    int drop;
    exp_t e;
    e_pulse(rs, 1'b0, b[7:4], 4, drop);
    idle(2);
    e_pulse(rs, 1'b0, b[3:0], 4, drop);
    if (exp_pulse) begin
      e.is_char = rs; e.row = row; e.col = col; e.code = b; e.due = drop + 2;
      sbq.push_back(e);
    end
    idle(3);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%02h required=%02h", name, act, req);
    end else begin
      $display("check ok %s value=%02h", name, act);
    end
  endtask

  task automatic init_seq();
    int drop;
    e_pulse(1'b0, 1'b0, 4'h3, 4, drop); idle(2);
    e_pulse(1'b0, 1'b0, 4'h3, 4, drop); idle(2);
    e_pulse(1'b0, 1'b0, 4'h3, 4, drop); idle(2);
    check("mode_before_switch", {7'd0, mode_4bit}, 8'd0);
    e_pulse(1'b0, 1'b0, 4'h2, 4, drop); idle(2);
    check("mode_after_switch", {7'd0, mode_4bit}, 8'd1);
  endtask

  function automatic void add(input bit rs, input logic [7:0] b, input bit row,
                              input logic [6:0] col);
    vec_t v;
    v.rs = rs; v.b = b; v.row = row; v.col = col;
    tbl.push_back(v);
  endfunction

  initial begin
    int drop;
    // rs, byte, expected row, expected column (ignored for commands)
    add(0, 8'h80, 0, 0);  add(1, 8'h41, 0, 0);
    add(0, 8'hC5, 0, 0);  add(1, 8'h42, 1, 5);   add(1, 8'h43, 1, 6);
    add(0, 8'hA7, 0, 0);  add(1, 8'h44, 0, 39);  add(1, 8'h45, 1, 0);
    add(0, 8'hC0, 0, 0);  add(0, 8'h04, 0, 0);   add(1, 8'h46, 1, 0);  add(1, 8'h47, 0, 39);
    add(0, 8'h06, 0, 0);  add(0, 8'h01, 0, 0);   add(1, 8'h48, 0, 0);
    add(0, 8'hE7, 0, 0);  add(1, 8'h49, 1, 39);  add(1, 8'h4A, 0, 0);
    add(0, 8'h02, 0, 0);  add(1, 8'h4B, 0, 0);
    add(0, 8'h30, 0, 0);  add(1, 8'h4C, 0, 1);
    add(0, 8'hA8, 0, 0);  add(1, 8'h4D, 0, 40);  add(1, 8'h4E, 0, 41);

    idle(3);
    check("reset_valids", {6'd0, char_valid, cmd_valid}, 8'd0);
    check("reset_mode_err", {4'd0, mode_4bit, err}, 8'd0);
    check("reset_char_code", char_code, 8'd0);
    check("reset_cmd_code", cmd_code, 8'd0);
    rst_n = 1'b1;
    idle(2);

    init_seq();
    for (int i = 0; i < tbl.size(); i++)
      send_byte(tbl[i].rs, tbl[i].b, 1'b1, tbl[i].row, tbl[i].col);
    check("err_illegal_addr", {5'd0, err}, 8'h02);

    // rs mismatch between nibbles, then realignment
    send_byte(0, 8'h85, 1'b1, 0, 0);
    e_pulse(1'b0, 1'b0, 4'h4, 4, drop); idle(2);
    e_pulse(1'b1, 1'b0, 4'hF, 4, drop); idle(3);
    check("err_rs_mismatch", {5'd0, err}, 8'h03);
    send_byte(1, 8'h50, 1'b1, 0, 5);

    // read strobe ignored: no error, no nibble consumed
    e_pulse(1'b1, 1'b1, 4'h5, 4, drop); idle(3);
    check("err_after_read", {5'd0, err}, 8'h03);
    send_byte(1, 8'h51, 1'b1, 0, 6);

    // short E pulse dropped and flagged
    e_pulse(1'b1, 1'b0, 4'h5, 1, drop); idle(3);
    check("err_short_e", {5'd0, err}, 8'h07);
    send_byte(1, 8'h52, 1'b1, 0, 7);

    // reset between nibbles of 0x41
    e_pulse(1'b1, 1'b0, 4'h4, 4, drop); idle(2);
    rst_n = 1'b0;
    idle(2);
    check("midbyte_reset_state", {4'd0, mode_4bit, err}, 8'd0);
    rst_n = 1'b1;
    idle(2);
    init_seq();
    send_byte(1, 8'h5A, 1'b1, 0, 0);
    check("err_after_reset_seq", {5'd0, err}, 8'd0);

    idle(4);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses got=%0d outstanding required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
